// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus around the ALU issue stage.
//   id_*      : fetch -> issue (valid/ready, instruction, PC)
//   rs*_data  : register-file reads for the presented instruction, same cycle
//   ex_*      : issue -> execute (valid/ready, operands, control, destination)
// slave  : the issue stage itself
// master : the environment (fetch, register file and execute side)
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu_a;
  logic [XLEN-1:0] ex_alu_b;
  logic [3:0]      ex_alu_control;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_illegal;

  modport slave (
    input  id_valid, id_instr, id_pc, rs1_data, rs2_data, ex_ready,
    output id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_control, ex_rd, ex_reg_write,
           ex_illegal
  );

  modport master (
    output id_valid, id_instr, id_pc, rs1_data, rs2_data, ex_ready,
    input  id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_control, ex_rd, ex_reg_write,
           ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage for the ALU: decodes OP, OP-IMM, LUI and AUIPC, selects operands
// and holds the result in a single-entry ID/EX register.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   bus           : id/ex handshake and operand bus (slave side)
//   flush         : synchronous kill of the held entry; wins over a same-cycle transfer
//   illegal_count : saturating count of accepted illegal instructions
module alu_issue_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus,
  input  logic             flush,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_u;
  logic            dec_legal;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [3:0]      dec_ctrl;
  logic            xfer;

  assign opcode = bus.id_instr[6:0];
  assign funct3 = bus.id_instr[14:12];
  assign funct7 = bus.id_instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.id_instr[31]}}, bus.id_instr[31:20]};
  assign imm_u  = {{(XLEN-32){1'b0}}, bus.id_instr[31:12], 12'b0};

  assign bus.id_ready = !ex_valid_q || bus.ex_ready;
  assign xfer         = bus.id_valid && bus.id_ready;

  // Decode of the presented instruction
  always_comb begin
    dec_legal = 1'b0;
    dec_a     = '0;
    dec_b     = '0;
    dec_ctrl  = 4'b0000;
    unique case (opcode)
      OpcOp: begin
        dec_a     = bus.rs1_data;
        dec_b     = bus.rs2_data;
        dec_ctrl  = {funct7[5], funct3};
        dec_legal = (funct7 == F7Zero) ||
                    ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OpcOpImm: begin
        dec_a     = bus.rs1_data;
        dec_b     = imm_i;
        dec_ctrl  = {1'b0, funct3};
        dec_legal = 1'b1;
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == F7Zero);
        end else if (funct3 == 3'b101) begin
          // Shift-right immediates reuse imm[11:5] as funct7 to pick SRL/SRA
          dec_ctrl  = {funct7[5], funct3};
          dec_legal = (funct7 == F7Zero) || (funct7 == F7Alt);
        end
      end
      OpcLui: begin
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OpcAuipc: begin
        dec_a     = bus.id_pc;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = 4'b0000;
    end
  end

  // ID/EX register and illegal counter next state
  always_comb begin
    ex_valid_d  = ex_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (xfer) begin
      ex_valid_d  = 1'b1;
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      ctrl_d      = dec_ctrl;
      rd_d        = bus.id_instr[11:7];
      reg_write_d = dec_legal && (bus.id_instr[11:7] != 5'd0);
      illegal_d   = !dec_legal;
      if (!dec_legal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ctrl_q      <= 4'b0000;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_alu_a       = alu_a_q;
  assign bus.ex_alu_b       = alu_b_q;
  assign bus.ex_alu_control = ctrl_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_illegal     = illegal_q;
  assign illegal_count      = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam logic [3:0] CAdd = 4'b0000, CSub = 4'b1000, CSll = 4'b0001, CSlt = 4'b0010;
  localparam logic [3:0] CSltu = 4'b0011, CXor = 4'b0100, CSrl = 4'b0101, CSra = 4'b1101;
  localparam logic [3:0] COr = 4'b0110, CAnd = 4'b0111;
  localparam int CntMax = 65535;

  typedef struct packed {
    logic        illegal;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] illegal_count;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flush        (flush),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference decode written as mnemonic tables
  function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
    dec_t        d;
    logic        ok;
    logic [31:0] immi;
    logic [31:0] immu;
    logic [6:0]  f7;
    logic [2:0]  f3;
    immi = {{20{ins[31]}}, ins[31:20]};
    immu = {ins[31:12], 12'h000};
    f7 = ins[31:25];
    f3 = ins[14:12];
    d = '0;
    ok = 1'b1;
    case (ins[6:0])
      7'b0110011: begin
        d.a = r1;
        d.b = r2;
        case ({f7, f3})
          {7'h00, 3'd0}: d.ctrl = CAdd;
          {7'h20, 3'd0}: d.ctrl = CSub;
          {7'h00, 3'd1}: d.ctrl = CSll;
          {7'h00, 3'd2}: d.ctrl = CSlt;
          {7'h00, 3'd3}: d.ctrl = CSltu;
          {7'h00, 3'd4}: d.ctrl = CXor;
          {7'h00, 3'd5}: d.ctrl = CSrl;
          {7'h20, 3'd5}: d.ctrl = CSra;
          {7'h00, 3'd6}: d.ctrl = COr;
          {7'h00, 3'd7}: d.ctrl = CAnd;
          default:       ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        d.a = r1;
        d.b = immi;
        case (f3)
          3'd0: d.ctrl = CAdd;
          3'd2: d.ctrl = CSlt;
          3'd3: d.ctrl = CSltu;
          3'd4: d.ctrl = CXor;
          3'd6: d.ctrl = COr;
          3'd7: d.ctrl = CAnd;
          3'd1: begin d.ctrl = CSll; ok = (f7 == 7'h00); end
          default: begin
            if (f7 == 7'h00) d.ctrl = CSrl;
            else if (f7 == 7'h20) d.ctrl = CSra;
            else ok = 1'b0;
          end
        endcase
      end
      7'b0110111: begin d.a = 32'h0; d.b = immu; d.ctrl = CAdd; end
      7'b0010111: begin d.a = pc;    d.b = immu; d.ctrl = CAdd; end
      default: ok = 1'b0;
    endcase
    d.rd = ins[11:7];
    if (!ok) begin
      d.a = 32'h0;
      d.b = 32'h0;
      d.ctrl = CAdd;
    end
    d.illegal = !ok;
    d.rw = ok && (d.rd != 5'd0);
    return d;
  endfunction

  // Behavioural model of the single-entry register
  dec_t m_dec;
  dec_t m_entry;
  logic m_valid;
  int   m_count;

  always_comb m_dec = model_decode(bus.id_instr, bus.id_pc, bus.rs1_data, bus.rs2_data);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_entry <= '0;
      m_count <= 0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (bus.id_valid && (!m_valid || bus.ex_ready)) begin
      m_valid <= 1'b1;
      m_entry <= m_dec;
      if (m_dec.illegal && m_count < CntMax) m_count <= m_count + 1;
    end else if (bus.ex_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: DUT against model every cycle, sampled on the falling edge
  always @(negedge clk) begin
    chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, m_valid});
    chk("id_ready", {31'b0, bus.id_ready}, {31'b0, !m_valid || bus.ex_ready});
    chk("illegal_count", {16'b0, illegal_count}, m_count);
    if (m_valid || !rst_n) begin
      chk("ex_alu_a", bus.ex_alu_a, m_entry.a);
      chk("ex_alu_b", bus.ex_alu_b, m_entry.b);
      chk("ex_alu_control", {28'b0, bus.ex_alu_control}, {28'b0, m_entry.ctrl});
      chk("ex_rd", {27'b0, bus.ex_rd}, {27'b0, m_entry.rd});
      chk("ex_reg_write", {31'b0, bus.ex_reg_write}, {31'b0, m_entry.rw});
      chk("ex_illegal", {31'b0, bus.ex_illegal}, {31'b0, m_entry.illegal});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic rdy,
                       input logic fl);
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.id_pc    = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.ex_ready = rdy;
    flush        = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    int          pick;
    int          f7sel;
    ins   = $urandom;
    pick  = $urandom_range(0, 9);
    f7sel = $urandom_range(0, 3);
    f7    = (f7sel < 2) ? 7'h00 : (f7sel == 2) ? 7'h20 : ins[31:25];
    if (pick <= 3)      begin ins[6:0] = 7'b0110011; ins[31:25] = f7; end
    else if (pick <= 6) begin ins[6:0] = 7'b0010011; ins[31:25] = f7; end
    else if (pick == 7) ins[6:0] = 7'b0110111;
    else if (pick == 8) ins[6:0] = 7'b0010111;
    return ins;
  endfunction

  initial begin
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk("rst ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst id_ready", {31'b0, bus.id_ready}, 32'h1);
    chk("rst count", {16'b0, illegal_count}, 32'h0);
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    step();
    chk("add valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("add a", bus.ex_alu_a, 32'd5);
    chk("add b", bus.ex_alu_b, 32'd7);
    chk("add ctrl", {28'b0, bus.ex_alu_control}, 32'h0);
    chk("add rd", {27'b0, bus.ex_rd}, 32'd3);
    chk("add rw", {31'b0, bus.ex_reg_write}, 32'h1);

    // SRAI x5,x6,3
    drive(1'b1, 32'h40335293, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
    step();
    chk("srai a", bus.ex_alu_a, 32'h80000000);
    chk("srai b", bus.ex_alu_b, 32'h00000403);
    chk("srai ctrl", {28'b0, bus.ex_alu_control}, 32'hD);
    chk("srai rd", {27'b0, bus.ex_rd}, 32'd5);

    // ADDI x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("addi b", bus.ex_alu_b, 32'hFFFFFFFF);
    chk("addi ctrl", {28'b0, bus.ex_alu_control}, 32'h0);

    // LUI x7,0x12345
    drive(1'b1, 32'h123453B7, 32'h0, 32'h55, 32'h66, 1'b1, 1'b0);
    step();
    chk("lui a", bus.ex_alu_a, 32'h0);
    chk("lui b", bus.ex_alu_b, 32'h12345000);

    // AUIPC x5,1 at pc 0x100
    drive(1'b1, 32'h00001297, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("auipc a", bus.ex_alu_a, 32'h100);
    chk("auipc b", bus.ex_alu_b, 32'h1000);

    // ADD x0,x1,x2
    drive(1'b1, 32'h00208033, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    step();
    chk("add x0 rw", {31'b0, bus.ex_reg_write}, 32'h0);

    // Backpressure: ADD captured, then three stalled cycles with SUB x4 presented
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h40208233, 32'h0, 32'd9, 32'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall id_ready", {31'b0, bus.id_ready}, 32'h0);
      chk("stall a", bus.ex_alu_a, 32'd5);
      chk("stall rd", {27'b0, bus.ex_rd}, 32'd3);
    end
    bus.ex_ready = 1'b1;
    step();
    chk("resume rd", {27'b0, bus.ex_rd}, 32'd4);
    chk("resume ctrl", {28'b0, bus.ex_alu_control}, 32'h8);
    drive(1'b1, 32'h002082B3, 32'h0, 32'd1, 32'd1, 1'b1, 1'b0);
    step();
    chk("b2b rd", {27'b0, bus.ex_rd}, 32'd5);
    chk("b2b valid", {31'b0, bus.ex_valid}, 32'h1);

    // Illegal opcode, then SUB with funct3=001
    drive(1'b1, 32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("ill1 flag", {31'b0, bus.ex_illegal}, 32'h1);
    chk("ill1 count", {16'b0, illegal_count}, 32'd1);
    drive(1'b1, 32'h40209033, 32'h0, 32'h3, 32'h4, 1'b1, 1'b0);
    step();
    chk("ill2 flag", {31'b0, bus.ex_illegal}, 32'h1);
    chk("ill2 rw", {31'b0, bus.ex_reg_write}, 32'h0);
    chk("ill2 count", {16'b0, illegal_count}, 32'd2);

    // Flush beats a same-cycle transfer
    drive(1'b1, 32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    chk("flush valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("flush count", {16'b0, illegal_count}, 32'd2);

    // Reset dropped mid-stall
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("arst a", bus.ex_alu_a, 32'h0);
    chk("arst rd", {27'b0, bus.ex_rd}, 32'h0);
    chk("arst count", {16'b0, illegal_count}, 32'h0);
    #2;
    rst_n = 1'b1;
    step();

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      step();
    end

    // Counter saturation from a clean reset
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 65536 + 3; i++) step();
    chk("sat count", {16'b0, illegal_count}, 32'h0000FFFF);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the ALU operand and control interface (operand A, operand B, 4-bit alu_control) from fetched RV32I instruction words.
- Decodes OP, OP-IMM, LUI and AUIPC.
- Selects register or immediate operands and registers the result into a single-entry ID/EX register.
- Uses valid/ready handshakes on both sides, plus synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction word valid from fetch.
- id_ready  out  1  stage can accept an instruction this cycle.
- id_instr  in  32  instruction word.
- id_pc  in  32  PC of id_instr.
- rs1_data  in  32  register-file read of id_instr[19:15], same cycle.
- rs2_data  in  32  register-file read of id_instr[24:20], same cycle.
- flush  in  1  synchronous kill of the held entry.
- ex_valid  out  1  ID/EX entry valid.
- ex_ready  in  1  execute stage accepts the entry.
- ex_alu_a  out  32  ALU operand A.
- ex_alu_b  out  32  ALU operand B.
- ex_alu_control  out  4  ALU operation code.
- ex_rd  out  5  destination register.
- ex_reg_write  out  1  write-back enable.
- ex_illegal  out  1  entry is an illegal/unsupported instruction.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset: asynchronous, on rst_n low. All outputs go to 0 immediately: ex_valid=0, all ex_* fields=0, illegal_count=0. id_ready=1 once the entry is empty (combinational).
- id_ready = !ex_valid || ex_ready, combinational. A transfer occurs when id_valid && id_ready.
- Transfer: on the rising edge, all ex_* fields capture the decoded values and ex_valid goes to 1. Latency is 1 cycle.
- Entry consumed, no new transfer (ex_valid && ex_ready with no input transfer): ex_valid goes to 0 and the fields hold their last values.
- Stall (ex_valid && !ex_ready): all ex_* outputs hold exactly.
- Consume and transfer in the same cycle: the new entry replaces the old, giving back-to-back throughput of 1 per cycle.
- flush: next cycle ex_valid=0. Flush has priority over a same-cycle transfer; the incoming instruction is dropped and illegal_count is not incremented for it. id_ready is not gated by flush.
- alu_control encoding:
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- OP (opcode 0110011):
  - A=rs1_data, B=rs2_data, control={funct7[5],funct3}.
  - Legal when funct7=0000000, or when funct7=0100000 and funct3 is 000 or 101.
- OP-IMM (opcode 0010011):
  - A=rs1_data, B=sign-extended instr[31:20], control={1'b0,funct3}.
  - funct3=001 (SLLI): legal only when funct7=0000000.
  - funct3=101: funct7=0000000 gives SRL; funct7=0100000 gives SRA (control=1101); any other funct7 is illegal.
- LUI (opcode 0110111): A=0, B={instr[31:12],12'b0}, control=ADD.
- AUIPC (opcode 0010111): A=id_pc, B={instr[31:12],12'b0}, control=ADD.
- Destination: ex_rd=instr[11:7]. ex_reg_write=1 only for a legal decode with rd!=0.
- Illegal (any other opcode or a bad funct7):
  - ex_illegal=1, ex_reg_write=0, A=B=0, control=ADD, ex_rd=instr[11:7].
  - illegal_count increments by 1 per accepted illegal instruction and saturates at all-ones, with no wrap.
- No internal state beyond the ID/EX register and the counter; no multi-cycle operations.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7, ex_ready=1 -> next cycle ex_valid=1, A=5, B=7, control=0000, rd=3, reg_write=1.
- SRAI x5,x6,3 (0x40335293), rs1_data=0x80000000 -> A=0x80000000, B=0x403, control=1101, rd=5.
- ADDI x1,x0,-1 (0xFFF00093) -> B=0xFFFFFFFF, control=0000.
- LUI x7,0x12345 (0x123453B7) -> A=0, B=0x12345000.
- AUIPC with id_pc=0x100 -> A=0x100.
- ADD x0,x1,x2 (0x00208033) -> reg_write=0.
- Backpressure: hold ex_ready=0 for 3 cycles after ADD is captured -> id_ready=0 and ex_* stable for all 3 cycles. Then raise ex_ready=1 with the next instruction presented -> 1/cycle throughput, no drop or duplicate.
- Illegal and flush:
  - Opcode 0x7F, then SUB with funct3=001 (0x40209033) -> ex_illegal=1 each time, illegal_count=2.
  - flush asserted together with a valid transfer -> ex_valid=0 next cycle, count unchanged.
- Reset and saturation:
  - Drop rst_n mid-stall -> ex_valid=0 immediately and all outputs 0.
  - Push 2^16+3 illegal instructions -> illegal_count=0xFFFF.
